// File: rtl/apsk_frame_gen.sv
// rtl/apsk_frame_gen.sv - framed 16-APSK baseband source: preamble, PRBS15 payload, zero gap
// Packs offset-binary I/Q DAC words into gp_out; every output is registered.
module apsk_frame_gen #(
    parameter int SPS          = 4,
    parameter int PREAMBLE_LEN = 32,
    parameter int PAYLOAD_LEN  = 256,
    parameter int GAP_LEN      = 16
) (
    input  logic        clk_30p72,
    input  logic        rst_n,
    input  logic        enable,
    output logic [27:0] gp_out,
    output logic [7:0]  leds_out,
    output logic        sym_strobe,
    output logic        frame_start
);

    localparam int SCW     = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int MAX_LEN = (PREAMBLE_LEN > PAYLOAD_LEN)
                             ? ((PREAMBLE_LEN > GAP_LEN) ? PREAMBLE_LEN : GAP_LEN)
                             : ((PAYLOAD_LEN > GAP_LEN) ? PAYLOAD_LEN : GAP_LEN);
    localparam int SYW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SPS - 1);
    localparam logic [SCW-1:0] SC_ONE      = SCW'(1);
    localparam logic [SYW-1:0] SY_ONE      = SYW'(1);
    localparam logic [SYW-1:0] PRE_LAST    = SYW'(PREAMBLE_LEN - 1);
    localparam logic [SYW-1:0] PAY_LAST    = SYW'(PAYLOAD_LEN - 1);
    localparam logic [SYW-1:0] GAP_LAST    = SYW'(GAP_LEN - 1);
    localparam logic [27:0]    GP_ZERO     = 28'h8002000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        GAP      = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [SCW-1:0] sample_cnt_q, sample_cnt_d;
    logic [SYW-1:0] sym_cnt_q, sym_cnt_d;
    logic [4:0]     frame_cnt_q, frame_cnt_d;
    logic [14:0]    lfsr_q, lfsr_d;
    logic [27:0]    gp_q, gp_d;
    logic [7:0]     leds_q, leds_d;
    logic           strobe_q, strobe_d;
    logic           fstart_q, fstart_d;

    logic [14:0]    lfsr_next;
    logic [3:0]     prbs_sym;
    logic           boundary;

    // Two's-complement value plus 8192 modulo 2^14 gives the offset-binary DAC code.
    function automatic logic [13:0] dac_word(input logic neg, input logic [12:0] mag);
        logic [13:0] v;
        v = neg ? (14'd0 - {1'b0, mag}) : {1'b0, mag};
        return v + 14'h2000;
    endfunction

    function automatic logic [27:0] map_sym(input logic [3:0] sym);
        logic [12:0] mi, mq;
        logic        si, sq;
        case (sym[1:0])
            2'd0:    begin mi = 13'd1448; mq = 13'd1448; end
            2'd1:    begin mi = 13'd5440; mq = 13'd1458; end
            2'd2:    begin mi = 13'd3982; mq = 13'd3982; end
            default: begin mi = 13'd1458; mq = 13'd5440; end
        endcase
        case (sym[3:2])
            2'd0:    begin si = 1'b0; sq = 1'b0; end
            2'd1:    begin si = 1'b1; sq = 1'b0; end
            2'd2:    begin si = 1'b1; sq = 1'b1; end
            default: begin si = 1'b0; sq = 1'b1; end
        endcase
        return {dac_word(si, mi), dac_word(sq, mq)};
    endfunction

    // Four PRBS15 steps in one cycle; the first bit produced lands in the symbol MSB.
    function automatic logic [18:0] prbs4(input logic [14:0] s);
        logic [14:0] t;
        logic [3:0]  sym;
        logic        b;
        t   = s;
        sym = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            b      = t[14] ^ t[13];
            t      = {t[13:0], b};
            sym[i] = b;
        end
        return {t, sym};
    endfunction

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        sym_cnt_d    = sym_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        lfsr_d       = lfsr_q;
        gp_d         = gp_q;
        strobe_d     = 1'b0;
        fstart_d     = 1'b0;
        {lfsr_next, prbs_sym} = prbs4(lfsr_q);
        boundary     = (sample_cnt_q == SAMPLE_LAST);

        if (state_q != IDLE) begin
            if (boundary) begin
                sample_cnt_d = '0;
                sym_cnt_d    = sym_cnt_q + SY_ONE;
                strobe_d     = 1'b1;
            end else begin
                sample_cnt_d = sample_cnt_q + SC_ONE;
            end
        end

        case (state_q)
            IDLE: begin
                gp_d = GP_ZERO;
                if (enable) begin
                    state_d      = PREAMBLE;
                    sample_cnt_d = '0;
                    sym_cnt_d    = '0;
                    gp_d         = map_sym(4'h2);
                    strobe_d     = 1'b1;
                    fstart_d     = 1'b1;
                end
            end
            PREAMBLE: begin
                if (boundary) begin
                    if (sym_cnt_q == PRE_LAST) begin
                        state_d   = PAYLOAD;
                        sym_cnt_d = '0;
                        gp_d      = map_sym(prbs_sym);
                        lfsr_d    = lfsr_next;
                    end else begin
                        gp_d = map_sym(sym_cnt_d[0] ? 4'hA : 4'h2);
                    end
                end
            end
            PAYLOAD: begin
                if (boundary) begin
                    if (sym_cnt_q == PAY_LAST) begin
                        state_d   = GAP;
                        sym_cnt_d = '0;
                        gp_d      = GP_ZERO;
                    end else begin
                        gp_d   = map_sym(prbs_sym);
                        lfsr_d = lfsr_next;
                    end
                end
            end
            default: begin
                gp_d = GP_ZERO;
                if (boundary && (sym_cnt_q == GAP_LAST)) begin
                    frame_cnt_d = frame_cnt_q + 5'd1;
                    sym_cnt_d   = '0;
                    if (enable) begin
                        state_d  = PREAMBLE;
                        gp_d     = map_sym(4'h2);
                        fstart_d = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        strobe_d = 1'b0;
                    end
                end
            end
        endcase

        leds_d = {frame_cnt_d, enable, state_d};
    end

    always_ff @(posedge clk_30p72 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            sym_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            lfsr_q       <= 15'h7FFF;
            gp_q         <= GP_ZERO;
            leds_q       <= '0;
            strobe_q     <= 1'b0;
            fstart_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            lfsr_q       <= lfsr_d;
            gp_q         <= gp_d;
            leds_q       <= leds_d;
            strobe_q     <= strobe_d;
            fstart_q     <= fstart_d;
        end
    end

    assign gp_out      = gp_q;
    assign leds_out    = leds_q;
    assign sym_strobe  = strobe_q;
    assign frame_start = fstart_q;

endmodule

// File: tb/tb_apsk_frame_gen.sv
// tb/tb_apsk_frame_gen.sv - scoreboard bench for apsk_frame_gen (SPS=4 default and a short SPS=1 build)
module tb_apsk_frame_gen;

    typedef struct packed {
        logic [27:0] gp;
        logic        st;
        logic        fs;
        logic [7:0]  leds;
    } obs_t;

    typedef struct packed {
        logic [27:0] gp;
        logic        st;
        logic        fs;
        logic [1:0]  state;
    } frm_t;

    localparam logic [27:0] GP_ZERO = 28'h8002000;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [27:0] gp0, gp1;
    logic [7:0]  leds0, leds1;
    logic        st0, st1, fs0, fs1;

    obs_t exp_q[2][$];
    frm_t frame_q[2][$];
    int   lfsr_m[2];
    int   fc_m[2];
    bit   fin_m[2];
    int   checks;
    int   errors;
    int   cycle;

    apsk_frame_gen u_dut0 (
        .clk_30p72  (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .gp_out     (gp0),
        .leds_out   (leds0),
        .sym_strobe (st0),
        .frame_start(fs0)
    );

    apsk_frame_gen #(.SPS(1), .PREAMBLE_LEN(3), .PAYLOAD_LEN(5), .GAP_LEN(2)) u_dut1 (
        .clk_30p72  (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .gp_out     (gp1),
        .leds_out   (leds1),
        .sym_strobe (st1),
        .frame_start(fs1)
    );

    initial clk = 1'b0;
    always #16 clk = ~clk;

    function automatic int cfg(input int d, input int k);
        int sps_t[2] = '{4, 1};
        int pre_t[2] = '{32, 3};
        int pay_t[2] = '{256, 5};
        int gap_t[2] = '{16, 2};
        case (k)
            0:       return sps_t[d];
            1:       return pre_t[d];
            2:       return pay_t[d];
            default: return gap_t[d];
        endcase
    endfunction

    function automatic logic [27:0] sym_word(input int sym);
        int mag_i[4] = '{1448, 5440, 3982, 1458};
        int mag_q[4] = '{1448, 1458, 3982, 5440};
        int quad, vi, vq;
        logic [13:0] wi, wq;
        quad = sym / 4;
        vi = mag_i[sym % 4];
        vq = mag_q[sym % 4];
        if (quad == 1 || quad == 2) vi = -vi;
        if (quad == 2 || quad == 3) vq = -vq;
        wi = 14'((vi + 8192 + 16384) % 16384);
        wq = 14'((vq + 8192 + 16384) % 16384);
        return {wi, wq};
    endfunction

    function automatic int prbs_bit(input int d);
        int b;
        b = ((lfsr_m[d] >> 14) ^ (lfsr_m[d] >> 13)) & 1;
        lfsr_m[d] = ((lfsr_m[d] << 1) | b) & 32'h7FFF;
        return b;
    endfunction

    task automatic build_frame(input int d);
        int   sps, sym;
        frm_t f;
        sps = cfg(d, 0);
        for (int s = 0; s < cfg(d, 1); s++) begin
            sym = (s % 2 == 0) ? 2 : 10;
            for (int k = 0; k < sps; k++) begin
                f = '{gp: sym_word(sym), st: (k == 0), fs: (k == 0 && s == 0), state: 2'd1};
                frame_q[d].push_back(f);
            end
        end
        for (int s = 0; s < cfg(d, 2); s++) begin
            sym = 0;
            for (int j = 0; j < 4; j++) sym = sym * 2 + prbs_bit(d);
            for (int k = 0; k < sps; k++) begin
                f = '{gp: sym_word(sym), st: (k == 0), fs: 1'b0, state: 2'd2};
                frame_q[d].push_back(f);
            end
        end
        for (int s = 0; s < cfg(d, 3); s++) begin
            for (int k = 0; k < sps; k++) begin
                f = '{gp: GP_ZERO, st: (k == 0), fs: 1'b0, state: 2'd3};
                frame_q[d].push_back(f);
            end
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                frame_q[d].delete();
                lfsr_m[d] = 32'h7FFF;
                fc_m[d]   = 0;
                fin_m[d]  = 1'b0;
                exp_q[d].push_back('{gp: GP_ZERO, st: 1'b0, fs: 1'b0, leds: 8'd0});
            end else begin
                frm_t f;
                if (frame_q[d].size() == 0) begin
                    if (fin_m[d]) begin
                        fc_m[d]  = (fc_m[d] + 1) % 32;
                        fin_m[d] = 1'b0;
                    end
                    if (enable) build_frame(d);
                end
                if (frame_q[d].size() > 0) begin
                    f = frame_q[d].pop_front();
                    exp_q[d].push_back('{gp: f.gp, st: f.st, fs: f.fs,
                                         leds: {5'(fc_m[d]), enable, f.state}});
                    if (frame_q[d].size() == 0) fin_m[d] = 1'b1;
                end else begin
                    exp_q[d].push_back('{gp: GP_ZERO, st: 1'b0, fs: 1'b0,
                                         leds: {5'(fc_m[d]), enable, 2'd0}});
                end
            end
        end
    end

    always @(negedge clk) begin
        obs_t got, e;
        cycle++;
        for (int d = 0; d < 2; d++) begin
            if (exp_q[d].size() > 0) begin
                e   = exp_q[d].pop_front();
                got = (d == 0) ? '{gp: gp0, st: st0, fs: fs0, leds: leds0}
                               : '{gp: gp1, st: st1, fs: fs1, leds: leds1};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL dut%0d_sample cycle %0d: got gp=%h strobe=%b fstart=%b leds=%b, want gp=%h strobe=%b fstart=%b leds=%b",
                             d, cycle, got.gp, got.st, got.fs, got.leds, e.gp, e.st, e.fs, e.leds);
                end
            end
        end
    end

    task automatic check_reset_state();
        checks++;
        if (gp0 !== GP_ZERO || st0 !== 1'b0 || fs0 !== 1'b0 || leds0 !== 8'd0 ||
            gp1 !== GP_ZERO || st1 !== 1'b0 || fs1 !== 1'b0 || leds1 !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: gp0=%h st0=%b fs0=%b leds0=%b gp1=%h st1=%b fs1=%b leds1=%b",
                     gp0, st0, fs0, leds0, gp1, st1, fs1, leds1);
        end
    endtask

    initial begin : frame_start_watchdog
        int waited;
        @(posedge rst_n);
        waited = 0;
        while (fs0 !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (fs0 !== 1'b1) begin
            errors++;
            $display("FAIL frame_start_wait: no frame_start within %0d cycles of reset release", waited);
        end
    end

    task automatic hold(input logic en, input int n);
        enable = en;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cycle  = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state();
        #1 rst_n = 1'b1;
        hold(1'b0, 3);
        hold(1'b1, 2432 + $urandom_range(300, 1000));
        hold(1'b0, 1300);
        for (int i = 0; i < 6; i++) hold(1'($urandom_range(0, 1)), $urandom_range(1, 400));
        hold(1'b0, 1300);
        hold(1'b1, 60);
        rst_n = 1'b0;
        hold(1'b1, 2);
        rst_n = 1'b1;
        hold(1'b1, 300);
        hold(1'b0, 1300);
        repeat (2) @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
